clock_enable_gen: RTL and testbench

- Parametrised successor to the fixed 50 MHz to 25 MHz / 1 MHz / 1 kHz clock divider.
- Runs entirely on the single 50 MHz system clock. Produces NUM_CH independent channels, each giving:
  - a one-cycle clock-enable strobe (tick), and
  - a divided square wave (sq).
- Divisors are runtime-programmable through a write port. Channels can be individually gated and phase-aligned together.
- CPU, RAM and VGA logic consume the tick strobes as clock enables instead of using derived clocks.

---
 rtl/clock_enable_gen.sv | 99 +++++++++
 tb/tb_clock_enable_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: NUM_CH programmable clock-enable generators on one system clock.
// Each channel emits a one-cycle tick every div cycles and a 50% square wave of
// period 2*div. Divisors are written at runtime; channels can be gated or cleared.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high; restores DIV_INIT and clears all state
//   ch_en    - per-channel run enable
//   sync_clr - clears every channel counter, tick and sq (phase alignment)
//   cfg_we   - divisor write strobe
//   cfg_ch   - channel index for the write
//   cfg_div  - new divisor (0 is rejected)
//   tick     - registered one-cycle enable strobe per channel
//   sq       - registered square wave per channel
//   cfg_err  - registered one-cycle pulse after a rejected write
module clock_enable_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CH_W   = 2,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd25000, 16'd25, 16'd1, 16'd1}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] sq_d;
  logic [NUM_CH-1:0] wr_hit;
  logic              cfg_err_d;

  // Write decode: a write lands only on an existing channel with a nonzero divisor.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i)) && (cfg_div != '0);
    end
    cfg_err_d = cfg_we && (wr_hit == '0);
  end

  // Per-channel next state. Clear and write take priority over a due tick.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      sq_d[i]   = sq[i];
      if (wr_hit[i]) begin
        div_d[i] = cfg_div;
      end
      if (sync_clr || wr_hit[i]) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (ch_en[i] && (div_q[i] != '0)) begin
        // div_q is nonzero here, so div-1 never wraps.
        if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_q[i] <= '0;
      end
      tick    <= '0;
      sq      <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick    <= tick_d;
      sq      <= sq_d;
      cfg_err <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: a 4-channel default build and a 3-channel build
// share stimulus. An independent phase-count model predicts every cycle's
// outputs into a scoreboard queue; tables and hand sequences add fixed checks.
module tb_clock_enable_gen;

  logic        clock;
  logic        reset;
  logic [3:0]  ch_en;
  logic        sync_clr;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  tick4, sq4;
  logic        err4;
  logic [2:0]  tick3, sq3;
  logic        err3;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  clock_enable_gen u_dut (
    .clock(clock), .reset(reset), .ch_en(ch_en), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick4), .sq(sq4), .cfg_err(err4)
  );

  clock_enable_gen #(
    .NUM_CH(3), .CNT_W(16), .CH_W(2),
    .DIV_INIT({16'd25, 16'd1, 16'd1})
  ) u_dut3 (
    .clock(clock), .reset(reset), .ch_en(ch_en[2:0]), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick3), .sq(sq3), .cfg_err(err3)
  );

  typedef struct packed {
    logic [3:0] tick;
    logic [3:0] sq;
    logic       err;
    logic [2:0] tick3;
    logic [2:0] sq3;
    logic       err3;
  } obs_t;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] div;
    logic        exp_err4;
    logic        exp_err3;
  } cfg_vec_t;

  obs_t exp_q[$];
  int   checks;
  int   errors;

  // Model: n = running edges since last restart; tick when n is a multiple of div.
  int         m_n   [4];
  int         m_div [4];
  logic [3:0] m_tick, m_sq;
  logic       m_err4, m_err3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_edge();
    bit wr;
    if (reset) begin
      m_div[0] = 1; m_div[1] = 1; m_div[2] = 25; m_div[3] = 25000;
      for (int i = 0; i < 4; i++) m_n[i] = 0;
      m_tick = '0; m_sq = '0; m_err4 = 1'b0; m_err3 = 1'b0;
    end else begin
      m_err4 = cfg_we && (cfg_div == 16'd0);
      m_err3 = cfg_we && ((cfg_ch >= 2'd3) || (cfg_div == 16'd0));
      for (int i = 0; i < 4; i++) begin
        wr = cfg_we && (cfg_div != 16'd0) && (int'(cfg_ch) == i);
        if (wr) m_div[i] = int'(cfg_div);
        if (sync_clr || wr) begin
          m_n[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        end else if (!ch_en[i] || m_div[i] == 0) begin
          m_tick[i] = 1'b0;
        end else begin
          m_n[i]++;
          m_tick[i] = (m_n[i] % m_div[i]) == 0;
          m_sq[i]   = ((m_n[i] / m_div[i]) % 2) == 1;
        end
      end
    end
  endtask

  // One clock edge: predict, queue, advance, then compare just after the edge.
  task automatic step();
    obs_t e, got;
    model_edge();
    e.tick = m_tick; e.sq = m_sq; e.err = m_err4;
    e.tick3 = m_tick[2:0]; e.sq3 = m_sq[2:0]; e.err3 = m_err3;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got.tick = tick4; got.sq = sq4; got.err = err4;
    got.tick3 = tick3; got.sq3 = sq3; got.err3 = err3;
    e = exp_q.pop_front();
    chk("scoreboard", 32'(got), 32'(e));
  endtask

  initial begin
    cfg_vec_t vecs [5];
    int cnt2, cnt3, first2, first3;

    checks = 0; errors = 0;
    vecs[0] = '{2'd3, 16'd7,  1'b0, 1'b1};
    vecs[1] = '{2'd1, 16'd0,  1'b1, 1'b1};
    vecs[2] = '{2'd3, 16'd0,  1'b1, 1'b1};
    vecs[3] = '{2'd0, 16'd0,  1'b1, 1'b1};
    vecs[4] = '{2'd2, 16'd25, 1'b0, 1'b0};

    reset = 1'b1; ch_en = 4'hF; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0;
    step();
    chk("reset_tick", 32'(tick4), 32'd0);
    chk("reset_sq", 32'(sq4), 32'd0);
    chk("reset_err", 32'(err4), 32'd0);
    reset = 1'b0;

    // Long run with default divisors.
    cnt2 = 0; cnt3 = 0; first3 = 0;
    for (int c = 1; c <= 50000; c++) begin
      step();
      if (tick4[2]) cnt2++;
      if (tick4[3]) begin
        cnt3++;
        if (first3 == 0) first3 = c;
      end
    end
    chk("tick2_count", 32'(cnt2), 32'd2000);
    chk("tick3_count", 32'(cnt3), 32'd2);
    chk("tick3_first", 32'(first3), 32'd25000);

    // Mid-count rewrite of ch2 to div 4.
    for (int k = 0; k < 7; k++) step();
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4;
    step();
    cfg_we = 1'b0;
    chk("wr_tick2", 32'(tick4[2]), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("div4_tick2", 32'(tick4[2]), 32'(k % 4 == 0));
    end

    // Write table: rejected writes pulse cfg_err for one cycle.
    foreach (vecs[v]) begin
      cfg_we = 1'b1; cfg_ch = vecs[v].ch; cfg_div = vecs[v].div;
      step();
      cfg_we = 1'b0;
      chk("cfg_err4", 32'(err4), 32'(vecs[v].exp_err4));
      chk("cfg_err3", 32'(err3), 32'(vecs[v].exp_err3));
      step();
      chk("cfg_err_pulse", 32'({err4, err3}), 32'd0);
    end

    // ch2 restarted at div 25 and has one running edge; bring cnt2 to 12.
    for (int k = 0; k < 11; k++) begin
      step();
      chk("pre_gate_tick2", 32'(tick4[2]), 32'd0);
    end
    ch_en[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("gated_tick2", 32'(tick4[2]), 32'd0);
    end
    ch_en[2] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("regate_tick2", 32'(tick4[2]), 32'(k == 13));
    end

    // Clear plus write on the edge where tick2 is due.
    for (int k = 0; k < 24; k++) step();
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd5;
    step();
    sync_clr = 1'b0; cfg_we = 1'b0;
    chk("clr_tick", 32'(tick4), 32'd0);
    chk("clr_sq", 32'(sq4), 32'd0);
    chk("clr_sq3", 32'(sq3), 32'd0);
    first2 = 0; first3 = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1) chk("clr_tick1", 32'(tick4[1]), 32'd1);
      if (tick4[2] && first2 == 0) first2 = k;
      if (tick4[3] && first3 == 0) first3 = k;
    end
    chk("clr_first2", 32'(first2), 32'd25);
    chk("clr_first3", 32'(first3), 32'd5);

    // Reset mid-run after a divisor write; a bad write during reset is ignored.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
    step();
    cfg_we = 1'b0;
    step(); step();
    reset = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd0;
    step();
    reset = 1'b0; cfg_we = 1'b0;
    chk("rst_tick", 32'(tick4), 32'd0);
    chk("rst_sq", 32'(sq4), 32'd0);
    chk("rst_err", 32'({err4, err3}), 32'd0);
    for (int k = 1; k <= 50; k++) begin
      step();
      chk("rst_tick0", 32'(tick4[0]), 32'd1);
      chk("rst_tick2", 32'(tick4[2]), 32'(k % 25 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
